// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
// ILLEGAL_TRAP_EN adds the TRAP state to state_t.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb
`ifdef ILLEGAL_TRAP_EN
    , StTrap
`endif
  } state_t;

  typedef enum logic [3:0] {
    ClsR, ClsImm, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsLui, ClsAuipc, ClsNone
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASS   = 2'b11;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational RV32I opcode to instruction-class decode; anything unrecognised is ClsNone.
module opcode_classifier
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls
);

  always_comb begin
    cls = ClsNone;
    case (opcode)
      OP_R:      cls = ClsR;
      OP_IMM:    cls = ClsImm;
      OP_LOAD:   cls = ClsLoad;
      OP_STORE:  cls = ClsStore;
      OP_BRANCH: cls = ClsBranch;
      OP_JAL:    cls = ClsJal;
      OP_JALR:   cls = ClsJalr;
      OP_LUI:    cls = ClsLui;
      OP_AUIPC:  cls = ClsAuipc;
      default:   cls = ClsNone;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main control FSM with memory-ack timeout.
// ILLEGAL_TRAP_EN: unknown opcodes enter a sticky TRAP state and raise illegal_instr.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ack,
  input  logic       br_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       instret,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegal_instr,
`endif
  output logic       mem_timeout
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t         state_q;
  instr_class_t   cls_q, cls_dec;
  logic [CntW-1:0] cnt_q;
  logic           req_stall, timeout_hit;

  opcode_classifier u_classifier (
    .opcode (opcode),
    .cls    (cls_dec)
  );

  assign req_stall   = mem_req && !mem_ack;
  assign timeout_hit = (MEM_TIMEOUT != 0) && req_stall &&
                       ((32'(cnt_q) + 32'd1) == 32'(MEM_TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFetch;
      cls_q       <= ClsNone;
      cnt_q       <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (timeout_hit) mem_timeout <= 1'b1;
      // Only FETCH/MEM stall; leaving them always needs ack or timeout, so this also
      // clears the counter on every state change.
      cnt_q <= (req_stall && !timeout_hit) ? cnt_q + 1'b1 : '0;
      case (state_q)
        StFetch: if (mem_ack) state_q <= StDecode;
        StDecode: begin
          cls_q <= cls_dec;
`ifdef ILLEGAL_TRAP_EN
          state_q <= (cls_dec == ClsNone) ? StTrap : StExec;
`else
          state_q <= StExec;
`endif
        end
        StExec: begin
          case (cls_q)
            ClsBranch, ClsNone: state_q <= StFetch;
            ClsLoad, ClsStore:  state_q <= StMem;
            default:            state_q <= StWb;
          endcase
        end
        StMem: begin
          if (timeout_hit)  state_q <= StFetch;
          else if (mem_ack) state_q <= (cls_q == ClsLoad) ? StWb : StFetch;
        end
        StWb: state_q <= StFetch;
`ifdef ILLEGAL_TRAP_EN
        StTrap: state_q <= StTrap;
`endif
        default: state_q <= StFetch;
      endcase
    end
  end

  // Outputs are decoded from state and forced low while reset is held, so an access
  // in flight is dropped in the same cycle reset arrives.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    instret   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    if (!reset) begin
      case (state_q)
        StFetch: begin
          mem_req  = 1'b1;
          ir_write = mem_ack;
          pc_write = mem_ack;
        end
        StExec: begin
          case (cls_q)
            ClsR:      alu_op = ALU_FUNCT;
            ClsImm:    begin alu_op = ALU_FUNCT; alu_src_b = 1'b1; end
            ClsLoad, ClsStore, ClsJalr: alu_src_b = 1'b1;
            ClsBranch: begin
              alu_op   = ALU_BRANCH;
              pc_write = br_taken;
              pc_src   = PC_REL;
              instret  = 1'b1;
            end
            ClsJal:    begin alu_op = ALU_PASS; alu_src_a = 1'b1; alu_src_b = 1'b1; end
            ClsLui:    begin alu_op = ALU_PASS; alu_src_b = 1'b1; end
            ClsAuipc:  begin alu_src_a = 1'b1; alu_src_b = 1'b1; end
            default:   instret = 1'b1;
          endcase
        end
        StMem: begin
          mem_req = 1'b1;
          mem_we  = (cls_q == ClsStore);
          instret = (cls_q == ClsStore) && mem_ack;
        end
        StWb: begin
          reg_write = 1'b1;
          instret   = 1'b1;
          case (cls_q)
            ClsLoad: wb_sel = WB_MEM;
            ClsJal:  begin wb_sel = WB_PC4; pc_write = 1'b1; pc_src = PC_REL; end
            ClsJalr: begin wb_sel = WB_PC4; pc_write = 1'b1; pc_src = PC_JALR; end
            default: wb_sel = WB_ALU;
          endcase
        end
`ifdef ILLEGAL_TRAP_EN
        StTrap: illegal_instr = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller (MEM_TIMEOUT=4); honours ILLEGAL_TRAP_EN.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ack, br_taken;
  logic       mem_req, mem_we, ir_write, pc_write, alu_src_a, alu_src_b, reg_write, instret;
  logic       mem_timeout, ill;
  logic [1:0] pc_src, alu_op, wb_sel;
  logic [15:0] obs;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  logic sticky = 1'b0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ack     (mem_ack),
    .br_taken    (br_taken),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .instret     (instret),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr (ill),
`endif
    .mem_timeout (mem_timeout)
  );

`ifndef ILLEGAL_TRAP_EN
  assign ill = 1'b0;
`endif

  assign obs = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
                reg_write, wb_sel, instret, mem_timeout, ill};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cw(input logic req, we, irw, pcw, input logic [1:0] pcs,
                                     input logic a, b, input logic [1:0] op, input logic rw,
                                     input logic [1:0] wb, input logic ret);
    return {req, we, irw, pcw, pcs, a, b, op, rw, wb, ret, 1'b0, 1'b0};
  endfunction

  // Drive one cycle of inputs and record what the outputs must be in that cycle.
  task automatic cyc(input logic ack, input logic br, input logic [15:0] exp, input string tag);
    mem_ack  = ack;
    br_taken = br;
    sb.push_back('{tag, exp | {14'b0, sticky, 1'b0}});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t e;
      e = sb.pop_front();
      check_eq(e.tag, obs, e.exp);
    end
  end

  logic [15:0] f_ack, f_wait, idle;

  initial begin
    f_ack  = cw(1, 0, 1, 1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0);
    f_wait = cw(1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0);
    idle   = 16'h0000;
    reset = 1'b1; opcode = 7'b0; mem_ack = 1'b0; br_taken = 1'b0;
    @(posedge clk); #1;
    cyc(1, 0, idle, "reset_idle");
    reset = 1'b0;

    // LW with fetch ack delayed three cycles; retires in cycle 8
    opcode = 7'b0000011;
    for (int i = 0; i < 3; i++) cyc(0, 0, f_wait, "lw_fwait");
    cyc(1, 0, f_ack, "lw_fetch");
    cyc(1, 0, idle, "lw_decode");
    cyc(1, 0, cw(0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00, 0), "lw_exec");
    cyc(1, 0, cw(1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0), "lw_mem");
    cyc(0, 0, cw(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 2'b01, 1), "lw_wb");

    // ADD
    opcode = 7'b0110011;
    cyc(1, 0, f_ack, "add_fetch");
    cyc(0, 0, idle, "add_decode");
    cyc(0, 0, cw(0, 0, 0, 0, 2'b00, 0, 0, 2'b10, 0, 2'b00, 0), "add_exec");
    cyc(0, 0, cw(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 2'b00, 1), "add_wb");

    // BEQ taken and not taken
    opcode = 7'b1100011;
    for (int t = 1; t >= 0; t--) begin
      cyc(1, 1'(t), f_ack, "beq_fetch");
      cyc(0, 1'(t), idle, "beq_decode");
      cyc(0, 1'(t), cw(0, 0, 0, 1'(t), 2'b01, 0, 0, 2'b01, 0, 2'b00, 1), "beq_exec");
    end

    // JALR
    opcode = 7'b1100111;
    cyc(1, 0, f_ack, "jalr_fetch");
    cyc(0, 0, idle, "jalr_decode");
    cyc(0, 0, cw(0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00, 0), "jalr_exec");
    cyc(0, 0, cw(0, 0, 0, 1, 2'b10, 0, 0, 2'b00, 1, 2'b10, 1), "jalr_wb");

    // SW completing normally
    opcode = 7'b0100011;
    cyc(1, 0, f_ack, "sw_fetch");
    cyc(0, 0, idle, "sw_decode");
    cyc(0, 0, cw(0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00, 0), "sw_exec");
    cyc(1, 0, cw(1, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 1), "sw_mem");

    // SW with no ack in MEM: times out after four request cycles
    cyc(1, 0, f_ack, "swto_fetch");
    cyc(0, 0, idle, "swto_decode");
    cyc(0, 0, cw(0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00, 0), "swto_exec");
    for (int i = 0; i < 4; i++)
      cyc(0, 0, cw(1, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0), "swto_mem");
    sticky = 1'b1;
    cyc(0, 0, f_wait, "swto_refetch");

    // ADD after timeout still works; flag stays set
    opcode = 7'b0110011;
    cyc(1, 0, f_ack, "add2_fetch");
    cyc(0, 0, idle, "add2_decode");
    cyc(0, 0, cw(0, 0, 0, 0, 2'b00, 0, 0, 2'b10, 0, 2'b00, 0), "add2_exec");
    cyc(0, 0, cw(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 2'b00, 1), "add2_wb");

    // Reset mid-MEM drops the request at once and clears the flag
    opcode = 7'b0000011;
    cyc(1, 0, f_ack, "rst_fetch");
    cyc(0, 0, idle, "rst_decode");
    cyc(0, 0, cw(0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00, 0), "rst_exec");
    cyc(0, 0, cw(1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0), "rst_mem");
    reset = 1'b1;
    sticky = 1'b0;
    cyc(1, 0, idle, "rst_held");
    reset = 1'b0;
    cyc(0, 0, f_wait, "rst_refetch");

    // Unknown (SYSTEM) opcode
    opcode = 7'b1110011;
    cyc(1, 0, f_ack, "sys_fetch");
    cyc(0, 0, idle, "sys_decode");
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0001, "trap_hold");
    reset = 1'b1;
    cyc(0, 0, idle, "trap_reset");
    reset = 1'b0;
`else
    cyc(0, 0, cw(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 1), "nop_exec");
`endif
    cyc(0, 0, f_wait, "final_fetch");

    @(negedge clk);
    #1;
    check_eq("sb_drain", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
